// File: rtl/reg_write_arbiter.sv
// Four-requester round-robin arbiter owning one shared register; a grant must be
// held for HOLD falling edges before the owner's data is written to q/qb.
module reg_write_arbiter #(
   parameter int WIDTH = 8,
   parameter int HOLD  = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [3:0]         req,
   input  logic [4*WIDTH-1:0] wdata,
   output logic [3:0]         gnt,
   output logic [WIDTH-1:0]   q,
   output logic [WIDTH-1:0]   qb,
   output logic               done,
   output logic               busy
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [3:0] CNT_LAST = 4'(HOLD - 1);

   state_t           state, state_nxt;
   logic [1:0]       ptr, ptr_nxt;
   logic [1:0]       sel, sel_nxt;
   logic [3:0]       cnt, cnt_nxt;
   logic [3:0]       gnt_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic             done_nxt;
   logic [1:0]       pick, idx;
   logic             found;

   // First requester at or after ptr, wrapping modulo 4
   always_comb begin
      pick  = ptr;
      idx   = ptr;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      sel_nxt   = sel;
      cnt_nxt   = cnt;
      gnt_nxt   = gnt;
      q_nxt     = q;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               sel_nxt   = pick;
               gnt_nxt   = 4'b0001 << pick;
               cnt_nxt   = 4'd0;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            // A dropped request releases the grant without writing
            if (!req[sel]) begin
               gnt_nxt   = 4'b0000;
               ptr_nxt   = sel + 2'd1;
               state_nxt = IDLE;
            end else if (cnt == CNT_LAST) begin
               q_nxt     = wdata[int'(sel)*WIDTH +: WIDTH];
               done_nxt  = 1'b1;
               gnt_nxt   = 4'b0000;
               ptr_nxt   = sel + 2'd1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 4'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         ptr   <= 2'd0;
         sel   <= 2'd0;
         cnt   <= 4'd0;
         gnt   <= 4'b0000;
         q     <= '0;
         qb    <= '1;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         sel   <= sel_nxt;
         cnt   <= cnt_nxt;
         gnt   <= gnt_nxt;
         q     <= q_nxt;
         qb    <= ~q_nxt;
         done  <= done_nxt;
      end
   end

   assign busy = (state == GRANT);

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, shared register data width in bits.
REQ-002 Parameter HOLD, default 2, falling edges a grant is held before the write; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on the falling edge of clk.
REQ-004 reset  input  1  asynchronous, active-high reset; acts immediately, independent of clk.
REQ-005 req  input  4  request vector; req[i] high = requester i wants to write the shared register.
REQ-006 wdata  input  4*WIDTH  requester i's data on wdata[i*WIDTH +: WIDTH].
REQ-007 gnt  output  4  registered one-hot grant, or all zero.
REQ-008 q  output  WIDTH  registered shared register value.
REQ-009 qb  output  WIDTH  registered bitwise complement of q.
REQ-010 done  output  1  one-cycle pulse, high for the cycle after a completed write.
REQ-011 busy  output  1  high while a grant is active (state GRANT).

Function
REQ-012 FSM states SHALL be exactly IDLE and GRANT.
REQ-013 Round-robin pointer ptr (2 bits) SHALL give priority order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-014 IDLE: on a falling edge with req != 0, the first set bit in pointer order is selected (sel), gnt <= one-hot(sel), hold counter cnt <= 0, state <= GRANT.
REQ-015 IDLE with req == 0: state, gnt, ptr, q, qb unchanged.
REQ-016 GRANT, req[sel]=1, cnt < HOLD-1: cnt <= cnt+1; gnt held.
REQ-017 GRANT, req[sel]=1, cnt == HOLD-1: q <= wdata of sel, qb <= ~wdata of sel, done <= 1, gnt <= 0, ptr <= sel+1 mod 4, state <= IDLE.
REQ-018 GRANT, req[sel]=0 on any falling edge: abort; no write to q/qb, done stays 0, gnt <= 0, ptr <= sel+1 mod 4, state <= IDLE.
REQ-019 Latency: req seen at edge k -> gnt high after edge k -> write and done after edge k+HOLD.
REQ-020 gnt SHALL be low for at least one full cycle between consecutive grants.
REQ-021 Requests from non-granted requesters during GRANT SHALL be ignored until IDLE.
REQ-022 Only wdata of the granted requester, sampled on the write edge, SHALL reach q.
REQ-023 done SHALL be high for exactly one cycle per completed write, otherwise 0.
REQ-024 busy SHALL equal (state == GRANT).
REQ-025 gnt SHALL never have more than one bit set.
REQ-026 Invariant: qb == ~q at all times outside reset assertion transients.
REQ-027 A HOLD value outside 1..15 is unsupported.

Reset
REQ-028 While reset is high: state=IDLE, gnt=0, q=0, qb=all ones, done=0, busy=0, ptr=0, cnt=0.
REQ-029 Reset asserted mid-GRANT SHALL abort immediately: no write, gnt cleared without waiting for a clk edge.
REQ-030 After reset deasserts, the first grant SHALL follow REQ-014 from ptr=0.

Verification
REQ-031 Reset -> q=0x00, qb=0xFF, gnt=0000, done=0, busy=0.
REQ-032 HOLD=2, req=0001, wdata0=0xA5 -> gnt=0001 for 2 cycles; q=0xA5, qb=0x5A; done one cycle; ptr=1.
REQ-033 req=1111 held, wdata i = 0x10+i -> grants in order 0001,0010,0100,1000,0001 with idle gaps; q sequence 0x10,0x11,0x12,0x13.
REQ-034 Grant to requester 2, then req[2] dropped before write -> gnt=0000 next edge, q unchanged, done=0, next grant searches from 3.
REQ-035 Reset asserted during GRANT with wdata=0x3C -> gnt=0000 and q=0x00 immediately; no done pulse.
REQ-036 HOLD=1, req=0100, wdata2=0xFF -> write on the edge after grant; q=0xFF, qb=0x00.
